// File: rtl/pass_mon_pkg.sv
// Shared types and default constants for the pass monitor and its LED driver.
package pass_mon_pkg;

    localparam int DEF_NUM           = 10;
    localparam int DEF_SETTLE_CYCLES = 256;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_BLINK_W       = 24;
    localparam int STATE_W           = 2;

    // Encodings are visible on state_out, so they are fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_FAIL    = 2'd3
    } state_e;

    // LED pattern per state: off, solid on, slow blink, fast blink.
    function automatic logic led_select(
        input state_e state,
        input logic   slow_bit,
        input logic   fast_bit
    );
        logic led;
        case (state)
            ST_IDLE:    led = 1'b0;
            ST_SETTLE:  led = 1'b1;
            ST_MONITOR: led = slow_bit;
            ST_FAIL:    led = fast_bit;
            default:    led = 1'b0;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/led_blinker.sv
// Free-running blink counter and registered LED mux driven by the monitor state.
// BLINK_W must be at least 3 so the fast-blink tap exists.
module led_blinker
    import pass_mon_pkg::*;
#(
    parameter int BLINK_W = DEF_BLINK_W
)
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  state_e i_state,
    output logic   o_led
);

    logic [BLINK_W-1:0] r_blink;
    logic [BLINK_W-1:0] w_blink_next;
    logic               r_led;

    // The counter wraps naturally modulo 2^BLINK_W.
    assign w_blink_next = r_blink + BLINK_W'(1);

    // Advance the blink counter and register the LED from the state being entered,
    // so led_out changes on the same edge as state_out.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_blink <= '0;
            r_led   <= 1'b0;
        end else begin
            r_blink <= w_blink_next;
            r_led   <= led_select(i_state, w_blink_next[BLINK_W-1], w_blink_next[BLINK_W-3]);
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/pass_monitor.sv
// Run-time monitor for an array of BRAM test instances: after a start request it
// ignores the pass bits for a settle window, then records any failing instance
// into sticky flags and a saturating fail-cycle counter until stopped.
module pass_monitor
    import pass_mon_pkg::*;
#(
    parameter int NUM           = DEF_NUM,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int BLINK_W       = DEF_BLINK_W
)
(
    input  logic             ref_clk_in,
    input  logic             reset,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic [NUM-1:0]   pass_in,
    output logic             pass_all_out,
    output logic             fail_out,
    output logic [NUM-1:0]   fail_vec_out,
    output logic [CNT_W-1:0] fail_count_out,
    output logic [1:0]       state_out,
    output logic             led_out
);

    localparam int SETTLE_CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_CW-1:0] SETTLE_LAST = SETTLE_CW'(SETTLE_CYCLES - 1);

    logic [NUM-1:0]       r_pass_q;
    state_e               r_state;
    logic [SETTLE_CW-1:0] r_settle_cnt;
    logic                 r_fail;
    logic [NUM-1:0]       r_fail_vec;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic                 r_pass_all;

    state_e               w_state_next;
    logic [SETTLE_CW-1:0] w_settle_cnt_next;
    logic                 w_fail_next;
    logic [NUM-1:0]       w_fail_vec_next;
    logic [CNT_W-1:0]     w_fail_cnt_next;
    logic [CNT_W-1:0]     w_fail_cnt_inc;
    logic                 w_any_zero;

    assign w_any_zero     = ~&r_pass_q;
    assign w_fail_cnt_inc = (r_fail_cnt == '1) ? r_fail_cnt : r_fail_cnt + CNT_W'(1);

    // Single input stage for the pass bits; all evaluation uses the registered copy.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values and simulation order cannot change the result.
    always_ff @(posedge ref_clk_in) begin
        if (!reset) begin
            r_pass_q <= '0;
        end else begin
            r_pass_q <= pass_in;
        end
    end

    // FSM state register.
    always_ff @(posedge ref_clk_in) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-datapath logic; stop always wins over start and over
    // recording a failure on the same cycle.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next      = r_state;
        w_settle_cnt_next = r_settle_cnt;
        w_fail_next       = r_fail;
        w_fail_vec_next   = r_fail_vec;
        w_fail_cnt_next   = r_fail_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start_in && !stop_in) begin
                    w_state_next      = ST_SETTLE;
                    w_settle_cnt_next = '0;
                    w_fail_next       = 1'b0;
                    w_fail_vec_next   = '0;
                    w_fail_cnt_next   = '0;
                end
            end
            ST_SETTLE: begin
                if (stop_in) begin
                    w_state_next = ST_IDLE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = ST_MONITOR;
                end else begin
                    w_settle_cnt_next = r_settle_cnt + SETTLE_CW'(1);
                end
            end
            ST_MONITOR: begin
                if (stop_in) begin
                    w_state_next = ST_IDLE;
                end else if (w_any_zero) begin
                    w_state_next    = ST_FAIL;
                    w_fail_next     = 1'b1;
                    w_fail_vec_next = r_fail_vec | ~r_pass_q;
                    w_fail_cnt_next = w_fail_cnt_inc;
                end
            end
            ST_FAIL: begin
                if (stop_in) begin
                    w_state_next = ST_IDLE;
                end else if (w_any_zero) begin
                    w_fail_vec_next = r_fail_vec | ~r_pass_q;
                    w_fail_cnt_next = w_fail_cnt_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and status outputs; pass_all follows the state being entered
    // so it lines up with state_out.
    always_ff @(posedge ref_clk_in) begin
        if (!reset) begin
            r_settle_cnt <= '0;
            r_fail       <= 1'b0;
            r_fail_vec   <= '0;
            r_fail_cnt   <= '0;
            r_pass_all   <= 1'b0;
        end else begin
            r_settle_cnt <= w_settle_cnt_next;
            r_fail       <= w_fail_next;
            r_fail_vec   <= w_fail_vec_next;
            r_fail_cnt   <= w_fail_cnt_next;
            r_pass_all   <= (w_state_next == ST_MONITOR);
        end
    end

    led_blinker #(
        .BLINK_W (BLINK_W)
    ) u_led_blinker (
        .i_clk   (ref_clk_in),
        .i_rst_n (reset),
        .i_state (w_state_next),
        .o_led   (led_out)
    );

    assign pass_all_out   = r_pass_all;
    assign fail_out       = r_fail;
    assign fail_vec_out   = r_fail_vec;
    assign fail_count_out = r_fail_cnt;
    assign state_out      = r_state;

endmodule

// File: tb/tb_pass_monitor.sv
// Self-checking bench for pass_monitor: directed table, hand-written corner
// sequences and randomized traffic against a run-level reference model.
module tb_pass_monitor;

    localparam int NUM     = 10;
    localparam int SETTLE  = 8;
    localparam int CNT_W   = 4;
    localparam int BLINK_W = 4;

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             start_in = 1'b0;
    logic             stop_in  = 1'b0;
    logic [NUM-1:0]   pass_in  = '1;
    logic             pass_all_out;
    logic             fail_out;
    logic [NUM-1:0]   fail_vec_out;
    logic [CNT_W-1:0] fail_count_out;
    logic [1:0]       state_out;
    logic             led_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is "active" from start until stop/reset; its phase is
    // derived from how long it has been running and whether anything failed.
    bit             m_active = 0;
    int             m_since  = 0;
    bit             m_failed = 0;
    logic [NUM-1:0] m_vec    = '0;
    int             m_cnt    = 0;
    int             m_ticks  = 0;
    logic [NUM-1:0] m_pass_q = '0;

    typedef struct {
        logic           rst;
        logic           start;
        logic           stop;
        logic [NUM-1:0] pass;
        logic [1:0]     e_state;
        logic           e_fail;
        logic           e_pass_all;
    } vec_t;

    vec_t tbl[9];

    pass_monitor #(
        .NUM           (NUM),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W),
        .BLINK_W       (BLINK_W)
    ) dut (
        .ref_clk_in     (clk),
        .reset          (reset),
        .start_in       (start_in),
        .stop_in        (stop_in),
        .pass_in        (pass_in),
        .pass_all_out   (pass_all_out),
        .fail_out       (fail_out),
        .fail_vec_out   (fail_vec_out),
        .fail_count_out (fail_count_out),
        .state_out      (state_out),
        .led_out        (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_state();
        if (!m_active)         return 0;
        if (m_since < SETTLE)  return 1;
        return m_failed ? 3 : 2;
    endfunction

    // Advance the model by one clock edge using the inputs presented to that edge.
    task automatic model_step();
        int s;
        if (!reset) begin
            m_active = 0; m_since = 0; m_failed = 0;
            m_vec = '0; m_cnt = 0; m_ticks = 0; m_pass_q = '0;
            return;
        end
        m_ticks++;
        s = m_state();
        if (s == 0) begin
            if (start_in && !stop_in) begin
                m_active = 1; m_since = 0; m_failed = 0; m_vec = '0; m_cnt = 0;
            end
        end else if (stop_in) begin
            m_active = 0;
        end else if (s == 1) begin
            m_since++;
        end else if (m_pass_q != {NUM{1'b1}}) begin
            m_failed = 1;
            m_vec    = m_vec | ~m_pass_q;
            m_cnt++;
        end
        m_pass_q = pass_in;
    endtask

    task automatic compare_model();
        int s;
        int led;
        s = m_state();
        case (s)
            1:       led = 1;
            2:       led = (m_ticks >> 3) & 1;
            3:       led = (m_ticks >> 1) & 1;
            default: led = 0;
        endcase
        check("model state", state_out, s);
        check("model pass_all", pass_all_out, (s == 2) ? 1 : 0);
        check("model fail", fail_out, m_failed);
        check("model fail_vec", fail_vec_out, m_vec);
        check("model fail_count", fail_count_out, (m_cnt > 15) ? 15 : m_cnt);
        check("model led", led_out, led);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic count_toggles(input int n, output int toggles);
        logic prev;
        prev    = led_out;
        toggles = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (led_out !== prev) toggles++;
            prev = led_out;
        end
    endtask

    initial begin
        int tg;

        // rst, start, stop, pass, expected state, fail, pass_all
        tbl[0] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 10'h3FF, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 10'h3FF, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 10'h000, 2'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 10'h000, 2'd1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 10'h3FF, 2'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 10'h3FF, 2'd1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 10'h3FF, 2'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 10'h3FF, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            reset    = tbl[i].rst;
            start_in = tbl[i].start;
            stop_in  = tbl[i].stop;
            pass_in  = tbl[i].pass;
            cycle();
            check("table state", state_out, tbl[i].e_state);
            check("table fail", fail_out, tbl[i].e_fail);
            check("table pass_all", pass_all_out, tbl[i].e_pass_all);
        end

        // Clean run: settle for exactly SETTLE cycles, then monitor with slow LED.
        reset = 1'b0; start_in = 1'b0; stop_in = 1'b0; pass_in = 10'h3FF;
        cycle();
        reset = 1'b1; start_in = 1'b1;
        cycle();
        check("clean settle entry", state_out, 1);
        start_in = 1'b0;
        for (int i = 0; i < SETTLE - 1; i++) begin
            cycle();
            check("clean settle hold", state_out, 1);
        end
        cycle();
        check("clean monitor entry", state_out, 2);
        check("clean pass_all", pass_all_out, 1);
        check("clean fail", fail_out, 0);
        count_toggles(32, tg);
        check("monitor led toggles", tg, 4);

        // Single one-cycle fail on instance 2: two-edge latency to fail_out.
        pass_in = 10'h3FB;
        cycle();
        check("single fail after 1 edge", fail_out, 0);
        pass_in = 10'h3FF;
        cycle();
        check("single fail flag", fail_out, 1);
        check("single fail vec", fail_vec_out, 10'h004);
        check("single fail count", fail_count_out, 1);
        check("single fail state", state_out, 3);
        check("single fail pass_all", pass_all_out, 0);
        count_toggles(16, tg);
        check("fail led toggles", tg, 8);
        check("single fail count held", fail_count_out, 1);

        // Saturation: every instance failing for 20 cycles.
        pass_in = 10'h000;
        repeat (20) cycle();
        check("sat vec", fail_vec_out, 10'h3FF);
        check("sat count", fail_count_out, 4'hF);

        // Stop in FAIL: back to IDLE with history retained.
        pass_in = 10'h3FF; stop_in = 1'b1;
        cycle();
        stop_in = 1'b0;
        check("stop state", state_out, 0);
        check("stop vec kept", fail_vec_out, 10'h3FF);
        check("stop count kept", fail_count_out, 4'hF);
        repeat (5) cycle();
        check("idle vec kept", fail_vec_out, 10'h3FF);
        check("idle fail kept", fail_out, 1);
        check("idle led", led_out, 0);

        // Settle masking: all-zero pass bits during settle are ignored.
        start_in = 1'b1; pass_in = 10'h000;
        cycle();
        check("restart clears vec", fail_vec_out, 0);
        check("restart clears count", fail_count_out, 0);
        start_in = 1'b0;
        repeat (SETTLE - 1) cycle();
        pass_in = 10'h3FF;
        repeat (5) cycle();
        check("mask state", state_out, 2);
        check("mask fail", fail_out, 0);
        check("mask vec", fail_vec_out, 0);

        // Reset mid-run discards history; no restart without a fresh start.
        pass_in = 10'h000;
        repeat (3) cycle();
        check("pre-reset state", state_out, 3);
        reset = 1'b0;
        cycle();
        check("reset state", state_out, 0);
        check("reset fail", fail_out, 0);
        check("reset vec", fail_vec_out, 0);
        check("reset count", fail_count_out, 0);
        check("reset led", led_out, 0);
        reset = 1'b1; pass_in = 10'h3FF;
        repeat (5) cycle();
        check("post-reset idle", state_out, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) != 0);
            start_in = ($urandom_range(0, 5) == 0);
            stop_in  = ($urandom_range(0, 29) == 0);
            pass_in  = ($urandom_range(0, 5) == 0) ? NUM'($urandom_range(0, 1023)) : 10'h3FF;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
